// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives a 1-cycle-latency
// instruction memory and applies stall/branch/jump/halt control.
module fetch_sequencer #(
  parameter int PC_W   = 12,
  parameter int INST_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic              jmp,
  input  logic [PC_W-1:0]   jmp_target,
  output logic [PC_W-1:0]   mem_addr,
  input  logic [INST_W-1:0] mem_q,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid,
  output logic              running,
  output logic              halted,
  output logic [15:0]       issue_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state_q;
  logic [PC_W-1:0] fa_q;
  logic [PC_W-1:0] q_pc_q;
  logic            q_v_q;
  logic [15:0]     cnt_q;

  logic run;
  logic accept;
  logic is_halt;
  logic hold;

  assign run        = (state_q == RUN);
  assign inst_valid = q_v_q & run;
  assign accept     = inst_valid & ~stall;
  assign is_halt    = (mem_q[INST_W-1 -: 4] == HALT_OP);
  // Re-read the held word while stalled so mem_q stays stable.
  assign hold       = run & stall & q_v_q;
  assign mem_addr   = hold ? q_pc_q : fa_q;

  assign inst      = mem_q;
  assign inst_pc   = q_pc_q;
  assign running   = run;
  assign halted    = (state_q == HALT);
  assign issue_cnt = cnt_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      fa_q    <= RESET_PC;
      q_pc_q  <= '0;
      q_v_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE, HALT: begin
          if (start) begin
            state_q <= RUN;
            fa_q    <= RESET_PC;
            q_v_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          if (br_taken) begin
            fa_q  <= br_target;
            q_v_q <= 1'b0;
          end else if (jmp) begin
            fa_q  <= jmp_target;
            q_v_q <= 1'b0;
          end else if (accept && is_halt) begin
            state_q <= HALT;
            q_v_q   <= 1'b0;
            cnt_q   <= cnt_q + 16'd1;
          end else if (stall && q_v_q) begin
            fa_q <= fa_q;
          end else begin
            q_pc_q <= fa_q;
            q_v_q  <= 1'b1;
            fa_q   <= fa_q + PC_W'(1);
            if (accept) cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a 1-cycle synchronous memory.
module tb_fetch_sequencer;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [11:0] br_target = '0;
  logic        jmp = 1'b0;
  logic [11:0] jmp_target = '0;
  logic [11:0] mem_addr;
  logic [15:0] mem_q = '0;
  logic [15:0] inst;
  logic [11:0] inst_pc;
  logic        inst_valid;
  logic        running;
  logic        halted;
  logic [15:0] issue_cnt;

  logic [15:0] mem [4096];

  int passed = 0;
  int total  = 0;

  fetch_sequencer dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jmp       (jmp),
    .jmp_target(jmp_target),
    .mem_addr  (mem_addr),
    .mem_q     (mem_q),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .inst_valid(inst_valid),
    .running   (running),
    .halted    (halted),
    .issue_cnt (issue_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) mem_q <= mem[mem_addr];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk_inst(input string tag,
                          input logic [11:0] pc,
                          input logic [15:0] word,
                          input logic [15:0] cnt);
    chk({tag, ".valid"}, 32'(inst_valid), 32'd1);
    chk({tag, ".pc"}, 32'(inst_pc), 32'(pc));
    chk({tag, ".inst"}, 32'(inst), 32'(word));
    chk({tag, ".cnt"}, 32'(issue_cnt), 32'(cnt));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h1000 + 16'(i);

    step(); step();
    reset = 1'b0;
    chk("rst.valid", 32'(inst_valid), 0);
    chk("rst.running", 32'(running), 0);
    chk("rst.halted", 32'(halted), 0);
    chk("rst.pc", 32'(inst_pc), 0);
    chk("rst.addr", 32'(mem_addr), 0);
    chk("rst.cnt", 32'(issue_cnt), 0);

    // basic fetch
    start = 1'b1;
    step();
    start = 1'b0;
    chk("e0.running", 32'(running), 1);
    chk("e0.valid", 32'(inst_valid), 0);
    step();
    chk_inst("f0", 12'h000, 16'h1000, 16'd0);
    step();
    chk_inst("f1", 12'h001, 16'h1001, 16'd1);
    step();
    chk_inst("f2", 12'h002, 16'h1002, 16'd2);
    step();
    chk_inst("f3", 12'h003, 16'h1003, 16'd3);
    step();
    chk_inst("f4", 12'h004, 16'h1004, 16'd4);
    step();
    chk_inst("f5", 12'h005, 16'h1005, 16'd5);

    // stall 3 cycles at pc 5
    stall = 1'b1;
    #1;
    chk("st.addr", 32'(mem_addr), 32'h005);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_inst("st", 12'h005, 16'h1005, 16'd5);
      chk("st.addr", 32'(mem_addr), 32'h005);
    end
    stall = 1'b0;
    step();
    chk_inst("st.after", 12'h006, 16'h1006, 16'd6);

    // branch and jump together: branch wins, word 6 discarded
    br_taken = 1'b1; br_target = 12'h040;
    jmp = 1'b1; jmp_target = 12'h080;
    step();
    br_taken = 1'b0; jmp = 1'b0;
    chk("rd.bubble", 32'(inst_valid), 0);
    chk("rd.cnt", 32'(issue_cnt), 6);
    step();
    chk_inst("rd.tgt", 12'h040, 16'h1040, 16'd6);

    // halt: jump to 0 and run into F000 at pc 3
    mem[3] = 16'hF000;
    jmp = 1'b1; jmp_target = 12'h000;
    step();
    jmp = 1'b0;
    chk("h.bubble", 32'(inst_valid), 0);
    step();
    chk_inst("h0", 12'h000, 16'h1000, 16'd6);
    step(); step(); step();
    chk_inst("h3", 12'h003, 16'hF000, 16'd9);
    step();
    chk("h.halted", 32'(halted), 1);
    chk("h.running", 32'(running), 0);
    chk("h.valid", 32'(inst_valid), 0);
    chk("h.cnt", 32'(issue_cnt), 10);
    jmp = 1'b1; jmp_target = 12'h123;
    step();
    jmp = 1'b0;
    chk("h.stay", 32'(halted), 1);

    // restart
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rs.running", 32'(running), 1);
    chk("rs.cnt", 32'(issue_cnt), 0);
    chk("rs.valid", 32'(inst_valid), 0);
    step();
    chk_inst("rs0", 12'h000, 16'h1000, 16'd0);

    // halt cancelled by jump to FFF, then wrap
    step(); step(); step();
    chk_inst("hc3", 12'h003, 16'hF000, 16'd3);
    jmp = 1'b1; jmp_target = 12'hFFF;
    step();
    jmp = 1'b0;
    chk("hc.halted", 32'(halted), 0);
    chk("hc.running", 32'(running), 1);
    chk("hc.valid", 32'(inst_valid), 0);
    chk("hc.cnt", 32'(issue_cnt), 3);
    step();
    chk_inst("w0", 12'hFFF, 16'h1FFF, 16'd3);
    step();
    chk_inst("w1", 12'h000, 16'h1000, 16'd4);
    step();
    chk_inst("w2", 12'h001, 16'h1001, 16'd5);

    // reset during a stall
    stall = 1'b1;
    step();
    chk_inst("rm.stall", 12'h001, 16'h1001, 16'd5);
    reset = 1'b1;
    step();
    chk("rm.running", 32'(running), 0);
    chk("rm.halted", 32'(halted), 0);
    chk("rm.valid", 32'(inst_valid), 0);
    chk("rm.addr", 32'(mem_addr), 0);
    chk("rm.cnt", 32'(issue_cnt), 0);
    chk("rm.pc", 32'(inst_pc), 0);
    reset = 1'b0; stall = 1'b0;
    step();
    chk("rm.idle", 32'(running), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the 16-bit processor. It owns the program counter and sequences the synchronous instruction memory, which has a 1-cycle read latency. It presents each fetched word with its address to decode, and applies the following control events:
- stalls from downstream;
- branch redirects from execute;
- jump redirects from decode;
- a halt opcode.

It replaces ad-hoc PC update logic in the top level and keeps an issued-instruction counter.

## Interface
- PC_W, 12, instruction address width
- INST_W, 16, instruction width
- RESET_PC, 0, fetch start address
- HALT_OP, 4'hF, opcode in inst[INST_W-1:INST_W-4] that stops fetch
- CLOCK_50  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high; clock CLOCK_50
- start  in  1  pulse: begin fetching from RESET_PC (sampled in IDLE/HALT only)
- stall  in  1  decode cannot accept the current instruction
- br_taken  in  1  execute redirect request
- br_target  in  PC_W  branch target
- jmp  in  1  decode redirect request
- jmp_target  in  PC_W  jump target
- mem_addr  out  PC_W  address to instruction memory (combinational)
- mem_q  in  INST_W  memory data; word for address captured at edge k valid after edge k
- inst  out  INST_W  = mem_q (passthrough)
- inst_pc  out  PC_W  address of word on inst
- inst_valid  out  1  inst holds a valid, non-squashed instruction
- running  out  1  state == RUN
- halted  out  1  state == HALT
- issue_cnt  out  16  instructions accepted by decode, wraps mod 2^16

## Operation
- **Registers**
  - state in {IDLE, RUN, HALT}
  - fa: next fetch address
  - q_pc: address of the word currently in mem_q
  - q_v: mem_q holds a valid word
  - issue_cnt
- **Reset values:** state=IDLE, fa=RESET_PC, q_pc=0, q_v=0, issue_cnt=0. This gives inst_valid=0, running=0, halted=0, inst_pc=0, mem_addr=RESET_PC.
- **Combinational outputs**
  - inst_valid = q_v & (state==RUN); inst_pc = q_pc.
  - mem_addr = q_pc when (state==RUN & stall & q_v), else fa. During a stall the memory therefore re-reads the held word and mem_q stays stable.
  - accept = inst_valid & ~stall.
- **IDLE:** on start go to RUN with fa=RESET_PC, q_v=0, issue_cnt=0. All other inputs are ignored.
- **RUN:** rules apply in priority order; only the first matching rule fires each edge.
  1. br_taken: fa<=br_target, q_v<=0.
  2. jmp: fa<=jmp_target, q_v<=0.
  3. accept and inst[top 4 bits]==HALT_OP: state<=HALT, q_v<=0, issue_cnt+1.
  4. stall & q_v: fa, q_pc, q_v and issue_cnt all hold.
  5. Otherwise (advance): q_pc<=fa, q_v<=1, fa<=fa+1 mod 2^PC_W, and issue_cnt+1 if accept.
- **HALT:** outputs inst_valid=0. On start, go to RUN as from IDLE; other inputs are ignored.
- **Redirect semantics**
  - Redirects discard the word in mem_q; that instruction is not counted even if stall=0.
  - br_taken wins over jmp because the branch is older.
  - A redirect in the same cycle as a HALT_OP instruction cancels the halt, since that instruction is wrong-path.
- **stall with q_v=0** (bubble cycle): treated as advance, because no instruction is held.
- **Wrap-around:** fa increments past 2^PC_W-1 to 0 with no flag.

## Timing
- start→first inst_valid:
  - edge E0 accepts start;
  - edge E1 captures RESET_PC (advance);
  - inst_valid=1 with inst_pc=RESET_PC in the cycle after E1.
- Steady state: 1 instruction per cycle, inst_pc incrementing by 1 per accepted instruction.
- Redirect penalty: exactly one bubble cycle (inst_valid=0) after the redirect edge; the target word is valid on the next cycle.
- Stall: inst, inst_pc and inst_valid are held unchanged for every stalled cycle. Issue resumes with the next address in the first cycle after stall falls.
- issue_cnt updates on the edge where accept=1 and is visible the following cycle.
- Reset mid-operation (any state, including during stall or redirect) returns all state to reset values on that edge. No instruction is accepted or counted in that cycle.

## Test plan
- **Basic fetch:** reset, start, memory[i]=16'h1000+i, stall=0 → inst_valid rises 2 edges after start. inst_pc=0,1,2,3 on consecutive cycles; inst=16'h1000..16'h1003; issue_cnt=4 after 4 accepts.
- **Stall:** stall=1 for 3 cycles while inst_pc=5 → inst_pc=5, inst=16'h1005, mem_addr=5 held. issue_cnt frozen; inst_pc=6 on the cycle after stall drops.
- **Redirect priority:** br_taken=1 (br_target=12'h040) and jmp=1 (jmp_target=12'h080) in the same cycle → one inst_valid=0 cycle, then inst_pc=12'h040. The discarded word is not counted.
- **Halt and restart:** memory[3]=16'hF000 → after accepting pc 3, halted=1, inst_valid=0, issue_cnt=4. start → running=1, issue_cnt=0, next inst_pc=0.
- **Halt cancelled and wrap:**
  - Halt cancelled: jmp asserted in the cycle HALT_OP is presented → no halt, next inst_pc=jmp_target.
  - Wrap: jmp_target=12'hFFF → inst_pc sequence FFF, 000, 001.
- **Reset mid-stall in RUN** → next cycle state IDLE, inst_valid=0, running=0, mem_addr=RESET_PC, issue_cnt=0.
